// File: rtl/fp16_result_packer.sv
// ---------------------------------------------------------------------------
// fp16_result_packer
//
// Collects single FP16 results from the GFP8->FP16 converter and packs LANES
// of them into one wide word. Completed words go into a small FIFO that
// drains to the result writer over a valid/ready handshake. An i_last input
// closes a partial word early. A completed word that cannot enter a full
// FIFO is dropped, and the drop is recorded in a sticky overflow flag.
//
// Ports
//   i_clk         clock
//   i_reset_n     asynchronous active-low reset
//   i_clear       synchronous flush of pack register, FIFO and overflow flag
//   i_fp16        FP16 result from the converter
//   i_valid       i_fp16 valid (no backpressure upstream)
//   i_last        with i_valid: this result closes the current word
//   o_word        FIFO head word; lane k at bits [16k+15:16k]; 0 when empty
//   o_word_lanes  populated lanes in o_word (1..LANES); 0 when empty
//   o_word_valid  FIFO head is valid
//   i_word_ready  consumer accepts o_word when o_word_valid & i_word_ready
//   o_fifo_count  FIFO occupancy, 0..FIFO_DEPTH
//   o_overflow    sticky: a completed word was dropped
// ---------------------------------------------------------------------------
module fp16_result_packer #(
  parameter int LANES      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_clear,
  input  logic [15:0]                     i_fp16,
  input  logic                            i_valid,
  input  logic                            i_last,
  output logic [16*LANES-1:0]             o_word,
  output logic [$clog2(LANES):0]          o_word_lanes,
  output logic                            o_word_valid,
  input  logic                            i_word_ready,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count,
  output logic                            o_overflow
);

  localparam int LW = $clog2(LANES);       // lane index width
  localparam int NW = LW + 1;              // lane count width (1..LANES)
  localparam int PW = $clog2(FIFO_DEPTH);  // FIFO pointer width
  localparam int CW = PW + 1;              // FIFO occupancy width
  localparam int WW = 16 * LANES;          // packed word width

  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  // Pack state
  logic [LW-1:0] lane_q, lane_d;
  logic [WW-1:0] pack_q, pack_d;

  // FIFO state
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [WW-1:0] mem_word  [FIFO_DEPTH];
  logic [NW-1:0] mem_lanes [FIFO_DEPTH];

  // Datapath / control
  logic [WW-1:0] fill_word;
  logic [NW-1:0] push_lanes;
  logic          word_done;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          mem_we;

  // Current pack register with this cycle's result merged into its lane.
  // Lanes above the current one are still zero because the pack register
  // is cleared on every push.
  always_comb begin
    fill_word = pack_q;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (LW'(k) == lane_q) begin
        fill_word[16*k +: 16] = i_fp16;
      end
    end
  end

  always_comb begin
    word_done  = i_valid && ((lane_q == LAST_LANE) || i_last);
    push_lanes = NW'(lane_q) + NW'(1);
    pop        = (count_q != '0) && i_word_ready;
    full       = (count_q == DEPTH_C);
    // A full FIFO still takes the word if the head leaves in the same cycle.
    push_ok    = word_done && (!full || pop);
    mem_we     = push_ok && !i_clear;
  end

  always_comb begin
    lane_d  = lane_q;
    pack_d  = pack_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (i_clear) begin
      // Flush wins over any input or handshake in the same cycle.
      lane_d  = '0;
      pack_d  = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (i_valid) begin
        if (word_done) begin
          lane_d = '0;
          pack_d = '0;
        end else begin
          lane_d = lane_q + LW'(1);
          pack_d = fill_word;
        end
      end

      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (push_ok) begin
        wptr_d = wptr_q + PW'(1);
      end

      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      if (word_done && !push_ok) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lane_q  <= '0;
      pack_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_word[wptr_q]  <= fill_word;
      mem_lanes[wptr_q] <= push_lanes;
    end
  end

  always_comb begin
    o_word_valid = (count_q != '0);
    o_word       = o_word_valid ? mem_word[rptr_q]  : '0;
    o_word_lanes = o_word_valid ? mem_lanes[rptr_q] : '0;
    o_fifo_count = count_q;
    o_overflow   = ovf_q;
  end

endmodule

// File: tb/tb_fp16_result_packer.sv
module tb_fp16_result_packer;

  localparam int LANES = 16;
  localparam int DEPTH = 8;
  localparam int W     = 16 * LANES;

  logic          i_clk;
  logic          i_reset_n;
  logic          i_clear;
  logic [15:0]   i_fp16;
  logic          i_valid;
  logic          i_last;
  logic [W-1:0]  o_word;
  logic [4:0]    o_word_lanes;
  logic          o_word_valid;
  logic          i_word_ready;
  logic [3:0]    o_fifo_count;
  logic          o_overflow;

  fp16_result_packer #(
    .LANES      (LANES),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (i_clear),
    .i_fp16       (i_fp16),
    .i_valid      (i_valid),
    .i_last       (i_last),
    .o_word       (o_word),
    .o_word_lanes (o_word_lanes),
    .o_word_valid (o_word_valid),
    .i_word_ready (i_word_ready),
    .o_fifo_count (o_fifo_count),
    .o_overflow   (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pack register, lane counter, sticky flag and a
  // scoreboard of expected FIFO contents.
  int           m_lane;
  logic [W-1:0] m_pack;
  logic         m_ovf;
  logic [W-1:0] sb_word[$];
  int           sb_lanes[$];

  task automatic check_eq(input string tag, input logic [W-1:0] act,
                          input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lane = 0;
    m_pack = '0;
    m_ovf  = 1'b0;
    sb_word.delete();
    sb_lanes.delete();
  endtask

  task automatic check_outputs();
    check_eq("count", W'(o_fifo_count), W'(sb_word.size()));
    check_eq("valid", W'(o_word_valid), W'(sb_word.size() != 0));
    check_eq("overflow", W'(o_overflow), W'(m_ovf));
    if (sb_word.size() != 0) begin
      check_eq("word", o_word, sb_word[0]);
      check_eq("lanes", W'(o_word_lanes), W'(sb_lanes[0]));
    end else begin
      check_eq("word_empty", o_word, '0);
      check_eq("lanes_empty", W'(o_word_lanes), '0);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the DUT
  // against the scoreboard, then advance the model across the rising edge.
  task automatic step(input logic v, input logic [15:0] d, input logic l,
                      input logic rdy, input logic clr);
    logic [W-1:0] nw;
    int           nl;
    bit           have;
    bit           pop;
    i_valid      = v;
    i_fp16       = d;
    i_last       = l;
    i_word_ready = rdy;
    i_clear      = clr;
    #1;
    check_outputs();
    pop  = (sb_word.size() != 0) && rdy;
    have = 1'b0;
    nw   = '0;
    nl   = 0;
    if (clr) begin
      model_reset();
    end else begin
      if (v) begin
        m_pack[16*m_lane +: 16] = d;
        if (m_lane == LANES - 1 || l) begin
          nw     = m_pack;
          nl     = m_lane + 1;
          have   = 1'b1;
          m_pack = '0;
          m_lane = 0;
        end else begin
          m_lane++;
        end
      end
      if (pop) begin
        void'(sb_word.pop_front());
        void'(sb_lanes.pop_front());
      end
      if (have) begin
        if (sb_word.size() < DEPTH) begin
          sb_word.push_back(nw);
          sb_lanes.push_back(nl);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic feed_rand(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 16'($urandom), 1'b0, rdy, 1'b0);
  endtask

  task automatic feed_inc(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 16'h3C00 + 16'(i), 1'b0, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_word"}, o_word, '0);
    check_eq({tag, "_lanes"}, W'(o_word_lanes), '0);
    check_eq({tag, "_valid"}, W'(o_word_valid), '0);
    check_eq({tag, "_count"}, W'(o_fifo_count), '0);
    check_eq({tag, "_ovf"}, W'(o_overflow), '0);
  endtask

  initial begin
    i_reset_n    = 1'b0;
    i_clear      = 1'b0;
    i_fp16       = '0;
    i_valid      = 1'b0;
    i_last       = 1'b0;
    i_word_ready = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Full word of 3C00+k with ready high.
    feed_inc(16, 1'b1);
    idle(3, 1'b1);

    // Partial word closed by i_last, then a one-lane word proving lane 0 restart.
    feed_rand(4, 1'b1);
    step(1'b1, 16'hABCD, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h1111, 1'b1, 1'b1, 1'b0);   // last without valid: ignored
    step(1'b1, 16'h5A5A, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // i_last on the final lane yields one full word only.
    feed_rand(15, 1'b1);
    step(1'b1, 16'h7777, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Overflow: nine words with ready low, then drain.
    feed_rand(9 * 16, 1'b0);
    idle(10, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);      // clear sticky flag
    idle(1, 1'b0);

    // Full FIFO with a pop in the cycle word 9 completes.
    feed_rand(8 * 16 + 15, 1'b0);
    step(1'b1, 16'hC0DE, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    check_eq("full_pop_ovf", W'(o_overflow), '0);
    check_eq("full_pop_count", W'(o_fifo_count), W'(DEPTH));
    idle(10, 1'b1);

    // Sustained back-to-back words with ready high.
    feed_rand(3 * 16, 1'b1);
    idle(3, 1'b1);

    // Clear with count=3, lane=7 and a concurrent valid.
    feed_rand(3 * 16 + 7, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b1);
    feed_inc(16, 1'b1);
    idle(3, 1'b1);

    // Asynchronous reset with count=2 and lane=10.
    feed_rand(2 * 16 + 10, 1'b0);
    #2;
    i_valid   = 1'b0;
    i_reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    idle(2, 1'b1);
    feed_inc(16, 1'b1);
    idle(3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
